// File: rtl/maltsev_pkg.sv
// ---------------------------------------------------------------------------
// maltsev_pkg
//   Shared definitions for the operation_* family of recursive-function
//   datapath operators.
//   Contents:
//     DEFAULT_BW  default word width of operands and results
//     state_t     two-state handshake FSM encoding (IDLE, DONE)
//     ST_REQ      level of ST that requests an operation
//     RD_VALID    level of RD that marks RES as valid
//     RD_IDLE     level of RD while no result is being presented
//     hs_next()   next-state function of the common ST/RD handshake
// ---------------------------------------------------------------------------
package maltsev_pkg;

    localparam int DEFAULT_BW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic ST_REQ   = 1'b1;
    localparam logic RD_VALID = 1'b1;
    localparam logic RD_IDLE  = 1'b0;

    // A request is accepted from IDLE and held in DONE until ST drops, so a
    // new request always needs at least one cycle with ST low in between.
    function automatic state_t hs_next(input state_t cur, input logic st);
        state_t nxt;
        nxt = cur;
        case (cur)
            IDLE:    nxt = (st == ST_REQ) ? DONE : IDLE;
            DONE:    nxt = (st == ST_REQ) ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/operand_select.sv
// ---------------------------------------------------------------------------
// operand_select
//   Static INC-to-1 selector of BW-bit operands. The selected index SI is a
//   parameter, so the "mux" collapses to wiring; unselected operands have no
//   path to the output at all.
//   Parameters:
//     BW   operand width
//     INC  number of operands
//     SI   index of the selected operand, 0..INC-1
//   Ports:
//     operands  in   INC x BW  packed operand vector, operands[i] = IN<i>
//     sel       out  BW        operands[SI]
// ---------------------------------------------------------------------------
module operand_select
    import maltsev_pkg::*;
#(
    parameter int BW  = DEFAULT_BW,
    parameter int INC = 2,
    parameter int SI  = 0
) (
    input  logic [INC-1:0][BW-1:0] operands,
    output logic [BW-1:0]          sel
);

    // An out-of-range projection index is a configuration error, not
    // something to clamp silently.
    if (SI < 0 || SI >= INC) begin : g_bad_si
        $error("operand_select: SI=%0d outside 0..%0d", SI, INC - 1);
    end

    if (BW < 1) begin : g_bad_bw
        $error("operand_select: BW=%0d must be at least 1", BW);
    end

    assign sel = operands[SI];

endmodule

// File: rtl/operation_i_bw16_inc2_si1.sv
// ---------------------------------------------------------------------------
// operation_i_bw16_inc2_si1
//   Maltsev projection primitive I(SI) of arity 2 over BW-bit words. On a
//   start request it registers operand IN<SI>, presents it on res and raises
//   rd one clock later. The result is held (inputs are not re-sampled) until
//   st drops.
//   Parameters:
//     BW   word width (default 16)
//     INC  arity, fixed at 2 by the port list
//     SI   projected operand index (default 1)
//   Ports:
//     rst  in   1   synchronous reset, active low
//     st   in   1   start request, level sensitive
//     clk  in   1   clock, rising edge
//     rd   out  1   high while res holds the result of the current request
//     res  out  BW  projected result, registered
//     in0  in   BW  operand 0
//     in1  in   BW  operand 1
// ---------------------------------------------------------------------------
module operation_i_bw16_inc2_si1
    import maltsev_pkg::*;
#(
    parameter int BW  = DEFAULT_BW,
    parameter int INC = 2,
    parameter int SI  = 1
) (
    input  logic          rst,
    input  logic          st,
    input  logic          clk,
    output logic          rd,
    output logic [BW-1:0] res,
    input  logic [BW-1:0] in0,
    input  logic [BW-1:0] in1
);

    if (INC != 2) begin : g_bad_inc
        $error("operation_i_bw16_inc2_si1: INC=%0d, port list provides 2 operands", INC);
    end

    logic [INC-1:0][BW-1:0] operands;
    logic [BW-1:0]          selected;

    state_t        state_q, state_d;
    logic [BW-1:0] res_q, res_d;
    logic          rd_q, rd_d;

    assign operands[0] = in0;
    assign operands[1] = in1;

    operand_select #(
        .BW  (BW),
        .INC (INC),
        .SI  (SI)
    ) u_operand_select (
        .operands (operands),
        .sel      (selected)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = hs_next(state_q, st);
        res_d   = res_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (st == ST_REQ) begin
                    res_d = selected;
                    rd_d  = RD_VALID;
                end else begin
                    rd_d  = RD_IDLE;
                end
            end
            DONE: begin
                // Result is frozen while the request is held; only the
                // falling edge of st releases it.
                rd_d = (st == ST_REQ) ? RD_VALID : RD_IDLE;
            end
            default: begin
                rd_d = RD_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            rd_q    <= RD_IDLE;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign rd  = rd_q;
    assign res = res_q;

endmodule

// File: tb/tb_operation_i_bw16_inc2_si1.sv
module tb_operation_i_bw16_inc2_si1;

    logic        clk;
    logic        rst;
    logic        st;
    logic        rd;
    logic [15:0] res;
    logic [15:0] in0;
    logic [15:0] in1;

    // Second configuration of the shared selector: SI=0, INC=3, BW=8.
    logic [2:0][7:0] sw_ops;
    logic [7:0]      sw_sel;

    int tests;
    int failed;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] last_res;

    operation_i_bw16_inc2_si1 dut (
        .rst (rst),
        .st  (st),
        .clk (clk),
        .rd  (rd),
        .res (res),
        .in0 (in0),
        .in1 (in1)
    );

    operand_select #(
        .BW  (8),
        .INC (3),
        .SI  (0)
    ) u_sweep (
        .operands (sw_ops),
        .sel      (sw_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        st  = 1'b0;
        in0 = 16'h0000;
        in1 = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (rd !== 1'b0) begin
                failed++;
                $display("FAIL reset_rd cycle %0d: got %b expected 0", i, rd);
            end
            tests++;
            if (res !== 16'h0000) begin
                failed++;
                $display("FAIL reset_res cycle %0d: got %h expected 0000", i, res);
            end
        end
    endtask

    task automatic test_start();
        rst = 1'b1;
        tick();
        tests++;
        if (rd !== 1'b0) begin
            failed++;
            $display("FAIL idle_rd: got %b expected 0", rd);
        end
        st = 1'b1;
        exp_q.push_back(in1);
        tick();
        tests++;
        if (rd !== 1'b1) begin
            failed++;
            $display("FAIL start_latency: rd got %b expected 1 one edge after st", rd);
        end
        exp_v = exp_q.pop_front();
        tests++;
        if (res !== exp_v) begin
            failed++;
            $display("FAIL start_res: got %h expected %h", res, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (rd !== 1'b1 || res !== exp_v) begin
                failed++;
                $display("FAIL start_hold cycle %0d: rd=%b res=%h expected rd=1 res=%h", i, rd, res, exp_v);
            end
        end
    endtask

    task automatic test_done_ignores_inputs();
        in1 = 16'hBEEF;
        in0 = 16'h4321;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (rd !== 1'b1 || res !== 16'h0001) begin
                failed++;
                $display("FAIL done_ignore cycle %0d: rd=%b res=%h expected rd=1 res=0001", i, rd, res);
            end
        end
    endtask

    task automatic test_release_restart();
        st = 1'b0;
        tick();
        tests++;
        if (rd !== 1'b0 || res !== 16'h0001) begin
            failed++;
            $display("FAIL release: rd=%b res=%h expected rd=0 res=0001", rd, res);
        end
        st  = 1'b1;
        in1 = 16'hFFFF;
        in0 = 16'h1234;
        exp_q.push_back(in1);
        tick();
        exp_v = exp_q.pop_front();
        tests++;
        if (rd !== 1'b1 || res !== exp_v) begin
            failed++;
            $display("FAIL restart: rd=%b res=%h expected rd=1 res=%h", rd, res, exp_v);
        end
    endtask

    task automatic test_idle_hold();
        st = 1'b0;
        tick();
        last_res = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            in0 = 16'(i * 16'h1111);
            in1 = 16'(16'h0F0F + i);
            tick();
            tests++;
            if (rd !== 1'b0 || res !== last_res) begin
                failed++;
                $display("FAIL idle_hold cycle %0d: rd=%b res=%h expected rd=0 res=%h", i, rd, res, last_res);
            end
        end
    endtask

    task automatic test_reset_mid_request();
        st  = 1'b1;
        in1 = 16'h7E57;
        exp_q.push_back(in1);
        tick();
        exp_v = exp_q.pop_front();
        tests++;
        if (rd !== 1'b1 || res !== exp_v) begin
            failed++;
            $display("FAIL pre_reset_req: rd=%b res=%h expected rd=1 res=%h", rd, res, exp_v);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (rd !== 1'b0 || res !== 16'h0000) begin
            failed++;
            $display("FAIL reset_mid: rd=%b res=%h expected rd=0 res=0000", rd, res);
        end
        // st stays high across the release: the first edge starts a request.
        in1 = 16'h5A5A;
        rst = 1'b1;
        exp_q.push_back(in1);
        tick();
        exp_v = exp_q.pop_front();
        tests++;
        if (rd !== 1'b1 || res !== exp_v) begin
            failed++;
            $display("FAIL reset_release_start: rd=%b res=%h expected rd=1 res=%h", rd, res, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            st = 1'b0;
            tick();
            tests++;
            if (rd !== 1'b0) begin
                failed++;
                $display("FAIL b2b_gap %0d: rd got %b expected 0", n, rd);
            end
            in0 = 16'($urandom);
            in1 = 16'($urandom);
            st  = 1'b1;
            exp_q.push_back(in1);
            tick();
            // Perturb the operands after capture; the result must not follow.
            in0 = ~in0;
            in1 = ~in1;
            tick();
            exp_v = exp_q.pop_front();
            tests++;
            if (rd !== 1'b1 || res !== exp_v) begin
                failed++;
                $display("FAIL b2b %0d: rd=%b res=%h expected rd=1 res=%h", n, rd, res, exp_v);
            end
        end
    endtask

    task automatic test_param_sweep();
        sw_ops[0] = 8'hA5;
        sw_ops[1] = 8'h3C;
        sw_ops[2] = 8'hC3;
        #1;
        tests++;
        if (sw_sel !== 8'hA5) begin
            failed++;
            $display("FAIL sweep_si0: got %h expected a5", sw_sel);
        end
        sw_ops[1] = 8'hFF;
        sw_ops[2] = 8'h00;
        #1;
        tests++;
        if (sw_sel !== 8'hA5) begin
            failed++;
            $display("FAIL sweep_unselected: got %h expected a5", sw_sel);
        end
        sw_ops[0] = 8'h5A;
        #1;
        tests++;
        if (sw_sel !== 8'h5A) begin
            failed++;
            $display("FAIL sweep_follow: got %h expected 5a", sw_sel);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        sw_ops = '0;
        test_reset();
        test_start();
        test_done_ignores_inputs();
        test_release_restart();
        test_idle_hold();
        test_reset_mid_request();
        test_back_to_back();
        test_param_sweep();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard stop in case a task never returns.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
